meas_reader: RTL and testbench
==============================

MEAS_READER -- requirements
Module: meas_reader

Interface
REQ-001 SHALL have parameter DEPTH, default 4, record FIFO depth; power of two, 2..16.
REQ-002 SHALL have parameter CNT_W, default 5, status count field width; must satisfy 2^CNT_W > DEPTH.
REQ-003 SHALL have port clk_i, input, 1, single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port reg_wr_en_i, input, 1, one-cycle strobe marking a valid 64-bit measurement record.
REQ-006 SHALL have port reg_wr_data_i, input, 64, measurement record, sampled when reg_wr_en_i=1.
REQ-007 SHALL have port s_axi_araddr, input, 4, read address; bits [1:0] ignored.
REQ-008 SHALL have port s_axi_arvalid, input, 1, address valid.
REQ-009 SHALL have port s_axi_arready, output, 1, address ready.
REQ-010 SHALL have port s_axi_rdata, output, 32, read data.
REQ-011 SHALL have port s_axi_rresp, output, 2, read response: 2'b00 OKAY, 2'b10 SLVERR.
REQ-012 SHALL have port s_axi_rvalid, output, 1, read data valid.
REQ-013 SHALL have port s_axi_rready, input, 1, read data ready.

Function
REQ-014 SHALL store records in a DEPTH x 64 FIFO; push on reg_wr_en_i when not full, or when full with a pop in the same cycle.
REQ-015 SHALL drop a record arriving when full with no same-cycle pop, and set sticky flag ovf.
REQ-016 SHALL keep count (0..DEPTH) exact under simultaneous push and pop; pointers wrap modulo DEPTH.
REQ-017 SHALL run the read FSM with states IDLE and RESP: IDLE has arready=1 and rvalid=0; on an AR handshake it goes to RESP with rvalid=1; on rvalid&&rready in RESP it returns to IDLE.
REQ-018 SHALL register rdata and rresp at the AR handshake; rvalid asserts on the next cycle; rdata and rresp stay stable while rvalid=1 and rready=0.
REQ-019 SHALL decode addr 0x0 DATA_LO as head[31:0], with no pop.
REQ-020 SHALL decode addr 0x4 DATA_HI as head[63:32] and pop the head on the R handshake.
REQ-021 SHALL decode addr 0x8 STATUS as {ovf, 0..., count in [CNT_W-1:0]}; the R handshake clears ovf unless an overflow occurs in the same cycle, in which case ovf stays 1.
REQ-022 SHALL decode addr 0xC INFO as the constant DEPTH.
REQ-023 SHALL return rdata=0 and rresp=SLVERR for a DATA_LO or DATA_HI read while empty; an empty DATA_HI read SHALL NOT pop.
REQ-024 SHALL return OKAY for all other reads.
REQ-025 SHALL snapshot the STATUS value at the AR handshake.
REQ-026 SHALL evaluate the DATA_HI pop on the R handshake; the head cannot change between AR and R because only this FSM pops.

Reset
REQ-027 SHALL, when rst_i=1 at a clock edge, force: FSM=IDLE, arready=1, rvalid=0, rdata=0, rresp=0, count=0, pointers=0, ovf=0.
REQ-028 SHALL give reset priority over a same-cycle push and AR handshake; reset during RESP SHALL drop the response.
REQ-029 SHALL NOT require FIFO storage to be cleared by reset.

Verification
REQ-030 SHALL cover: push 64'h1122334455667788 then read 0x0 -> 32'h55667788 OKAY; read 0x4 -> 32'h11223344 OKAY; read 0x8 -> count=0.
REQ-031 SHALL cover: 5 pushes at DEPTH=4 -> STATUS=32'h80000004; reading STATUS again -> 32'h00000004; the 5th record is absent.
REQ-032 SHALL cover: read 0x4 while empty -> rdata=0, rresp=2'b10, count stays 0.
REQ-033 SHALL cover: FIFO full, push coincident with the DATA_HI R handshake -> push accepted, count=4, ovf=0.
REQ-034 SHALL cover: rready held low 10 cycles -> rvalid=1 and rdata stable throughout, arready=0; arready=1 on the cycle after the handshake.
REQ-035 SHALL cover: rst_i pulsed in RESP with 3 records stored -> next cycle rvalid=0, arready=1, STATUS read returns 0.

Source files
------------

// File: rtl/meas_reader.sv
// rtl/meas_reader.sv - measurement record FIFO exposed through a read-only AXI-Lite style port
module meas_reader #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        reg_wr_en_i,
  input  logic [63:0] reg_wr_data_i,
  input  logic [3:0]  s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] ADDR_DATA_LO = 2'd0;
  localparam logic [1:0] ADDR_DATA_HI = 2'd1;
  localparam logic [1:0] ADDR_STATUS  = 2'd2;
  localparam logic [1:0] ADDR_INFO    = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    ST_IDLE,
    ST_RESP
  } state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [1:0]        addr_q, addr_d;

  logic [63:0]       mem_q [DEPTH];

  logic              ar_hs;
  logic              r_hs;
  logic              empty;
  logic              full;
  logic              pop;
  logic              push;
  logic              overflow;
  logic [63:0]       head;
  logic [31:0]       status_val;
  logic [31:0]       rd_val;
  logic [1:0]        rd_resp;

  // Byte-lane bits of the address carry no meaning for word registers.
  logic unused_addr_bits;
  assign unused_addr_bits = ^s_axi_araddr[1:0];

  assign ar_hs    = (state_q == ST_IDLE) && s_axi_arvalid;
  assign r_hs     = (state_q == ST_RESP) && s_axi_rready;
  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  // Only a DATA_HI response with data behind it consumes the head record.
  assign pop      = r_hs && (addr_q == ADDR_DATA_HI) && !empty;
  // A full FIFO still accepts a record when the head leaves in the same cycle.
  assign push     = reg_wr_en_i && (!full || pop);
  assign overflow = reg_wr_en_i && full && !pop;
  assign head     = mem_q[rd_ptr_q];

  assign s_axi_arready = (state_q == ST_IDLE);
  assign s_axi_rvalid  = (state_q == ST_RESP);
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;

  // Decode the requested register from the live FIFO/status state.
  always_comb begin
    status_val            = '0;
    status_val[31]        = ovf_q;
    status_val[CNT_W-1:0] = count_q;
    rd_val                = '0;
    rd_resp               = RESP_OKAY;
    case (s_axi_araddr[3:2])
      ADDR_DATA_LO: begin
        if (empty) begin
          rd_resp = RESP_SLVERR;
        end else begin
          rd_val = head[31:0];
        end
      end
      ADDR_DATA_HI: begin
        if (empty) begin
          rd_resp = RESP_SLVERR;
        end else begin
          rd_val = head[63:32];
        end
      end
      ADDR_STATUS: rd_val = status_val;
      ADDR_INFO:   rd_val = 32'(DEPTH);
      default:     rd_val = '0;
    endcase
  end

  // Read channel FSM: accept an address in IDLE, hold the response in RESP.
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    addr_d  = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (ar_hs) begin
          state_d = ST_RESP;
          rdata_d = rd_val;
          rresp_d = rd_resp;
          addr_d  = s_axi_araddr[3:2];
        end
      end
      ST_RESP: begin
        if (r_hs) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // A STATUS response clears the flag, but a drop in that same cycle wins.
    if (r_hs && (addr_q == ADDR_STATUS)) begin
      ovf_d = 1'b0;
    end
    if (overflow) begin
      ovf_d = 1'b1;
    end
  end

  // Control and response registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
      addr_q   <= ADDR_DATA_LO;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      addr_q   <= addr_d;
    end
  end

  // Record storage; contents are left as-is by reset since pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      mem_q[wr_ptr_q] <= reg_wr_data_i;
    end
  end

endmodule

// File: tb/tb_meas_reader.sv
// tb/tb_meas_reader.sv - self-checking bench for meas_reader
module tb_meas_reader;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_i;
  logic        reg_wr_en_i;
  logic [63:0] reg_wr_data_i;
  logic [3:0]  s_axi_araddr;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;

  int          errors;
  int          checks;
  logic [63:0] model_q [$];
  bit          m_ovf;
  logic [33:0] exp_q [$];

  meas_reader #(.DEPTH(DEPTH), .CNT_W(5)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .reg_wr_en_i   (reg_wr_en_i),
    .reg_wr_data_i (reg_wr_data_i),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [33:0] model_read(input logic [3:0] addr);
    logic [63:0] h;
    case (addr[3:2])
      2'd0: begin
        if (model_q.size() == 0) return {2'b10, 32'h0};
        h = model_q[0];
        return {2'b00, h[31:0]};
      end
      2'd1: begin
        if (model_q.size() == 0) return {2'b10, 32'h0};
        h = model_q[0];
        return {2'b00, h[63:32]};
      end
      2'd2:    return {2'b00, m_ovf, 31'(model_q.size())};
      default: return {2'b00, 32'(DEPTH)};
    endcase
  endfunction

  task automatic model_push(input logic [63:0] d);
    if (model_q.size() < DEPTH) model_q.push_back(d);
    else m_ovf = 1'b1;
  endtask

  task automatic do_push(input logic [63:0] d);
    @(negedge clk);
    reg_wr_en_i   = 1'b1;
    reg_wr_data_i = d;
    @(negedge clk);
    reg_wr_en_i   = 1'b0;
    model_push(d);
  endtask

  task automatic do_read(input logic [3:0] addr, input int hold, input bit push_at_r,
                         input logic [63:0] pd, input string name);
    int          n;
    logic [33:0] first;
    logic [33:0] exp;
    @(negedge clk);
    s_axi_araddr  = addr;
    s_axi_arvalid = 1'b1;
    s_axi_rready  = 1'b0;
    n = 0;
    while (!s_axi_arready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (s_axi_arready !== 1'b1) begin
      errors++;
      $display("FAIL %s_arready: got %b expected 1", name, s_axi_arready);
      s_axi_arvalid = 1'b0;
      return;
    end
    exp_q.push_back(model_read(addr));
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    n = 0;
    while (!s_axi_rvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (s_axi_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL %s_rvalid: got %b expected 1", name, s_axi_rvalid);
      void'(exp_q.pop_front());
      return;
    end
    first = {s_axi_rresp, s_axi_rdata};
    for (int i = 0; i < hold; i++) begin
      checks++;
      if (s_axi_rvalid !== 1'b1 || {s_axi_rresp, s_axi_rdata} !== first || s_axi_arready !== 1'b0) begin
        errors++;
        $display("FAIL %s_hold%0d: got rvalid=%b resp/data=%h arready=%b expected 1/%h/0",
                 name, i, s_axi_rvalid, {s_axi_rresp, s_axi_rdata}, s_axi_arready, first);
      end
      @(negedge clk);
    end
    exp = exp_q.pop_front();
    checks++;
    if ({s_axi_rresp, s_axi_rdata} !== exp) begin
      errors++;
      $display("FAIL %s_data: got resp=%b data=%h expected resp=%b data=%h",
               name, s_axi_rresp, s_axi_rdata, exp[33:32], exp[31:0]);
    end
    s_axi_rready = 1'b1;
    if (push_at_r) begin
      reg_wr_en_i   = 1'b1;
      reg_wr_data_i = pd;
    end
    @(negedge clk);
    s_axi_rready = 1'b0;
    reg_wr_en_i  = 1'b0;
    if (addr[3:2] == 2'd1 && model_q.size() > 0) void'(model_q.pop_front());
    if (addr[3:2] == 2'd2) m_ovf = 1'b0;
    if (push_at_r) model_push(pd);
    checks++;
    if (s_axi_rvalid !== 1'b0 || s_axi_arready !== 1'b1) begin
      errors++;
      $display("FAIL %s_after: got rvalid=%b arready=%b expected 0/1", name, s_axi_rvalid, s_axi_arready);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    model_q.delete();
    m_ovf = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    model_q.delete();
    m_ovf = 1'b0;
    checks++;
    if (s_axi_arready !== 1'b1 || s_axi_rvalid !== 1'b0 || s_axi_rdata !== 32'h0 || s_axi_rresp !== 2'b00) begin
      errors++;
      $display("FAIL reset_outputs: got arready=%b rvalid=%b rdata=%h rresp=%b expected 1/0/0/00",
               s_axi_arready, s_axi_rvalid, s_axi_rdata, s_axi_rresp);
    end
    do_read(4'h8, 0, 0, 64'h0, "reset_status");
  endtask

  task automatic test_basic();
    do_push(64'h1122334455667788);
    do_read(4'h0, 0, 0, 64'h0, "basic_lo");
    do_read(4'h4, 0, 0, 64'h0, "basic_hi");
    do_read(4'h8, 0, 0, 64'h0, "basic_status");
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) do_push({32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i)});
    do_read(4'h8, 0, 0, 64'h0, "ovf_status1");
    do_read(4'h8, 0, 0, 64'h0, "ovf_status2");
    for (int i = 0; i < 4; i++) begin
      do_read(4'h0, 0, 0, 64'h0, $sformatf("ovf_drain_lo%0d", i));
      do_read(4'h4, 0, 0, 64'h0, $sformatf("ovf_drain_hi%0d", i));
    end
    do_read(4'h0, 0, 0, 64'h0, "ovf_fifth_absent");
  endtask

  task automatic test_empty_hi();
    do_read(4'h4, 0, 0, 64'h0, "empty_hi");
    do_read(4'h8, 0, 0, 64'h0, "empty_hi_status");
  endtask

  task automatic test_full_concurrent();
    for (int i = 0; i < 4; i++) do_push({$urandom, $urandom});
    do_read(4'h4, 0, 1, 64'hDEAD_BEEF_CAFE_F00D, "fullpush_hi");
    do_read(4'h8, 0, 0, 64'h0, "fullpush_status");
    for (int i = 0; i < 4; i++) begin
      do_read(4'h0, 0, 0, 64'h0, $sformatf("fullpush_lo%0d", i));
      do_read(4'h4, 0, 0, 64'h0, $sformatf("fullpush_hi%0d", i));
    end
  endtask

  task automatic test_backpressure();
    do_push(64'h0123_4567_89AB_CDEF);
    do_read(4'h4, 10, 0, 64'h0, "bp_hi");
    do_read(4'hD, 3, 0, 64'h0, "bp_info");
  endtask

  task automatic test_reset_resp();
    for (int i = 0; i < 3; i++) do_push({$urandom, $urandom});
    @(negedge clk);
    s_axi_araddr  = 4'h8;
    s_axi_arvalid = 1'b1;
    s_axi_rready  = 1'b0;
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    checks++;
    if (s_axi_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL rstresp_inresp: got rvalid=%b expected 1", s_axi_rvalid);
    end
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    model_q.delete();
    m_ovf = 1'b0;
    checks++;
    if (s_axi_rvalid !== 1'b0 || s_axi_arready !== 1'b1) begin
      errors++;
      $display("FAIL rstresp_dropped: got rvalid=%b arready=%b expected 0/1", s_axi_rvalid, s_axi_arready);
    end
    do_read(4'h8, 0, 0, 64'h0, "rstresp_status");
  endtask

  task automatic test_back_to_back();
    logic [63:0] d;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      d = {$urandom, $urandom};
      reg_wr_en_i   = 1'b1;
      reg_wr_data_i = d;
      model_push(d);
      @(negedge clk);
    end
    reg_wr_en_i = 1'b0;
    do_read(4'h8, 0, 0, 64'h0, "b2b_status");
    for (int i = 0; i < 3; i++) begin
      do_read(4'h0, i, 0, 64'h0, $sformatf("b2b_lo%0d", i));
      do_read(4'h4, 0, 0, 64'h0, $sformatf("b2b_hi%0d", i));
    end
    do_read(4'h4, 0, 0, 64'h0, "b2b_empty");
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    m_ovf         = 1'b0;
    rst_i         = 1'b1;
    reg_wr_en_i   = 1'b0;
    reg_wr_data_i = '0;
    s_axi_araddr  = '0;
    s_axi_arvalid = 1'b0;
    s_axi_rready  = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_empty_hi();
    test_full_concurrent();
    test_backpressure();
    test_reset_resp();
    apply_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
